// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported memory between the instruction-fetch stage (IF)
// and the load/store stage (MEM). Each accepted request becomes one memory
// transaction. The transaction holds ram_req and its fields until ram_ack.
// Completion is then reported to the requester as a one-cycle valid pulse
// with the read data. MEM wins ties. After MAX_CONSEC consecutive MEM grants
// taken while IF was waiting, IF wins the next tie. A flush (if_cancel)
// during a fetch lets the memory finish but swallows the result.
//
// Ports
//   clk, reset_b                 clock, synchronous active-high reset
//   if_req/if_addr/if_cancel     fetch request, address, flush pulse
//   if_rdata/if_valid            fetch data and completion pulse
//   mem_req/mem_we/mem_addr/
//   mem_wdata                    load/store request and its fields
//   mem_rdata/mem_valid          load data (0 for stores), completion pulse
//   ram_req/ram_we/ram_addr/
//   ram_wdata                    memory request, held until ram_ack
//   ram_rdata/ram_ack            memory read data and completion
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_CONSEC = 4
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_cancel,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_valid,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack
);

    localparam int               CNT_W   = $clog2(MAX_CONSEC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CONSEC);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY_IF  = 2'd1,
        ST_BUSY_MEM = 2'd2
    } state_t;

    state_t            state_r,     state_nxt_s;
    logic              ram_req_r,   ram_req_nxt_s;
    logic              ram_we_r,    ram_we_nxt_s;
    logic [ADDR_W-1:0] ram_addr_r,  ram_addr_nxt_s;
    logic [DATA_W-1:0] ram_wdata_r, ram_wdata_nxt_s;
    logic              if_valid_r,  if_valid_nxt_s;
    logic [DATA_W-1:0] if_rdata_r,  if_rdata_nxt_s;
    logic              mem_valid_r, mem_valid_nxt_s;
    logic [DATA_W-1:0] mem_rdata_r, mem_rdata_nxt_s;
    logic [CNT_W-1:0]  starve_r,    starve_nxt_s;
    logic              drop_r,      drop_nxt_s;

    logic              mem_elig_s;
    logic              if_elig_s;
    logic              starve_at_max_s;
    logic              grant_if_s;
    logic              grant_mem_s;

    // A requester whose valid pulse is showing is finishing, not asking again;
    // a fetch being flushed this cycle is not worth starting.
    assign mem_elig_s      = mem_req & ~mem_valid_r;
    assign if_elig_s       = if_req & ~if_valid_r & ~if_cancel;
    assign starve_at_max_s = (starve_r == CNT_MAX);
    assign grant_if_s      = if_elig_s & (~mem_elig_s | starve_at_max_s);
    assign grant_mem_s     = mem_elig_s & ~grant_if_s;

    // Next-state and next-output logic of the transaction sequencer.
    always_comb begin
        state_nxt_s     = state_r;
        ram_req_nxt_s   = ram_req_r;
        ram_we_nxt_s    = ram_we_r;
        ram_addr_nxt_s  = ram_addr_r;
        ram_wdata_nxt_s = ram_wdata_r;
        if_valid_nxt_s  = 1'b0;
        if_rdata_nxt_s  = if_rdata_r;
        mem_valid_nxt_s = 1'b0;
        mem_rdata_nxt_s = mem_rdata_r;
        starve_nxt_s    = starve_r;
        drop_nxt_s      = drop_r;

        case (state_r)
            ST_IDLE: begin
                drop_nxt_s = 1'b0;
                if (grant_if_s) begin
                    state_nxt_s     = ST_BUSY_IF;
                    ram_req_nxt_s   = 1'b1;
                    ram_we_nxt_s    = 1'b0;
                    ram_addr_nxt_s  = if_addr;
                    ram_wdata_nxt_s = {DATA_W{1'b0}};
                    starve_nxt_s    = {CNT_W{1'b0}};
                end else if (grant_mem_s) begin
                    state_nxt_s     = ST_BUSY_MEM;
                    ram_req_nxt_s   = 1'b1;
                    ram_we_nxt_s    = mem_we;
                    ram_addr_nxt_s  = mem_addr;
                    ram_wdata_nxt_s = mem_wdata;
                    // Count only MEM grants that made a waiting fetch wait longer.
                    if (if_req) begin
                        if (starve_at_max_s) begin
                            starve_nxt_s = starve_r;
                        end else begin
                            starve_nxt_s = starve_r + CNT_ONE;
                        end
                    end else begin
                        starve_nxt_s = {CNT_W{1'b0}};
                    end
                end else if (!if_req) begin
                    starve_nxt_s = {CNT_W{1'b0}};
                end else begin
                    starve_nxt_s = starve_r;
                end
            end

            ST_BUSY_IF: begin
                if (ram_ack) begin
                    state_nxt_s   = ST_IDLE;
                    ram_req_nxt_s = 1'b0;
                    ram_we_nxt_s  = 1'b0;
                    drop_nxt_s    = 1'b0;
                    // A flush seen earlier or in this very cycle swallows the result.
                    if (drop_r || if_cancel) begin
                        if_valid_nxt_s = 1'b0;
                    end else begin
                        if_valid_nxt_s = 1'b1;
                        if_rdata_nxt_s = ram_rdata;
                    end
                end else if (if_cancel) begin
                    drop_nxt_s = 1'b1;
                end else begin
                    drop_nxt_s = drop_r;
                end
            end

            ST_BUSY_MEM: begin
                if (ram_ack) begin
                    state_nxt_s     = ST_IDLE;
                    ram_req_nxt_s   = 1'b0;
                    ram_we_nxt_s    = 1'b0;
                    mem_valid_nxt_s = 1'b1;
                    if (ram_we_r) begin
                        mem_rdata_nxt_s = {DATA_W{1'b0}};
                    end else begin
                        mem_rdata_nxt_s = ram_rdata;
                    end
                end else begin
                    state_nxt_s = ST_BUSY_MEM;
                end
            end

            default: begin
                state_nxt_s   = ST_IDLE;
                ram_req_nxt_s = 1'b0;
                ram_we_nxt_s  = 1'b0;
                drop_nxt_s    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset_b) begin
            state_r     <= ST_IDLE;
            ram_req_r   <= 1'b0;
            ram_we_r    <= 1'b0;
            ram_addr_r  <= {ADDR_W{1'b0}};
            ram_wdata_r <= {DATA_W{1'b0}};
            if_valid_r  <= 1'b0;
            if_rdata_r  <= {DATA_W{1'b0}};
            mem_valid_r <= 1'b0;
            mem_rdata_r <= {DATA_W{1'b0}};
            starve_r    <= {CNT_W{1'b0}};
            drop_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            ram_req_r   <= ram_req_nxt_s;
            ram_we_r    <= ram_we_nxt_s;
            ram_addr_r  <= ram_addr_nxt_s;
            ram_wdata_r <= ram_wdata_nxt_s;
            if_valid_r  <= if_valid_nxt_s;
            if_rdata_r  <= if_rdata_nxt_s;
            mem_valid_r <= mem_valid_nxt_s;
            mem_rdata_r <= mem_rdata_nxt_s;
            starve_r    <= starve_nxt_s;
            drop_r      <= drop_nxt_s;
        end
    end

    assign ram_req   = ram_req_r;
    assign ram_we    = ram_we_r;
    assign ram_addr  = ram_addr_r;
    assign ram_wdata = ram_wdata_r;
    assign if_valid  = if_valid_r;
    assign if_rdata  = if_rdata_r;
    assign mem_valid = mem_valid_r;
    assign mem_rdata = mem_rdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a reference model.
module tb_mem_port_arbiter;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MAX_CONSEC = 4;

    logic              clk = 1'b0;
    logic              reset_b;
    logic              if_req, if_cancel, if_valid;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              mem_req, mem_we, mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              ram_req, ram_we, ram_ack;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_CONSEC(MAX_CONSEC)) dut (
        .clk(clk), .reset_b(reset_b),
        .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ack(ram_ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the memory (0 nobody, 1 fetch, 2 load/store),
    // the transaction being presented, and what each requester is being shown.
    int          m_owner = 0;
    int          m_starve = 0;
    bit          m_req = 0, m_we = 0, m_drop = 0, m_if_valid = 0, m_mem_valid = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_if_rdata = 0, m_mem_rdata = 0;

    // Memory responder state.
    logic [31:0] ram_store [logic [31:0]];
    int          ack_lat = 0, cur_lat = 0, age = 0;
    bit          rand_mode = 0, force_ack = 0, prev_req = 0;
    logic [31:0] grant_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (ram_store.exists(a)) return ram_store[a];
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // One clock edge of the model, using the inputs that were held during the cycle.
    task automatic model_step();
        bit want_mem, want_if;
        bit shown_if, shown_mem;
        shown_if    = m_if_valid;
        shown_mem   = m_mem_valid;
        m_if_valid  = 0;
        m_mem_valid = 0;
        if (reset_b) begin
            m_owner = 0; m_starve = 0; m_req = 0; m_we = 0; m_drop = 0;
            m_addr = 0; m_wdata = 0; m_if_rdata = 0; m_mem_rdata = 0;
        end else if (m_owner == 0) begin
            want_mem = mem_req && !shown_mem;
            want_if  = if_req && !shown_if && !if_cancel;
            if (want_if && (!want_mem || m_starve == MAX_CONSEC)) begin
                m_owner = 1; m_req = 1; m_we = 0; m_addr = if_addr; m_wdata = 0;
                m_starve = 0;
            end else if (want_mem) begin
                m_owner = 2; m_req = 1; m_we = mem_we; m_addr = mem_addr; m_wdata = mem_wdata;
                m_starve = if_req ? ((m_starve + 1 > MAX_CONSEC) ? MAX_CONSEC : m_starve + 1) : 0;
            end else if (!if_req) begin
                m_starve = 0;
            end
            m_drop = 0;
        end else begin
            if (m_owner == 1 && if_cancel) m_drop = 1;
            if (ram_ack) begin
                if (m_owner == 1) begin
                    if (!m_drop) begin
                        m_if_valid = 1;
                        m_if_rdata = ram_rdata;
                    end
                end else begin
                    m_mem_valid = 1;
                    m_mem_rdata = m_we ? 32'h0 : ram_rdata;
                end
                m_owner = 0; m_req = 0; m_we = 0; m_drop = 0;
            end
        end
    endtask

    // Memory side: acknowledge after a chosen latency, keep a real backing store.
    task automatic respond();
        int lat;
        lat = rand_mode ? cur_lat : ack_lat;
        if (force_ack) begin
            ram_ack   = 1'b1;
            force_ack = 0;
        end else if (ram_req) begin
            if (age >= lat) begin
                ram_ack = 1'b1;
                if (ram_we) ram_store[ram_addr] = ram_wdata;
                ram_rdata = ram_we ? 32'($urandom) : rd_word(ram_addr);
            end else begin
                ram_ack = 1'b0;
                age++;
            end
        end else begin
            age       = 0;
            cur_lat   = $urandom_range(0, 3);
            ram_ack   = rand_mode && ($urandom_range(0, 7) == 0);
            ram_rdata = 32'($urandom);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        check("ram_req", ram_req, m_req);
        if (m_req) begin
            check("ram_we", ram_we, m_we);
            check("ram_addr", ram_addr, m_addr);
            check("ram_wdata", ram_wdata, m_wdata);
        end
        check("if_valid", if_valid, m_if_valid);
        check("if_rdata", if_rdata, m_if_rdata);
        check("mem_valid", mem_valid, m_mem_valid);
        check("mem_rdata", mem_rdata, m_mem_rdata);
        if (ram_req && !prev_req) grant_q.push_back(ram_addr);
        prev_req = ram_req;
        respond();
    endtask

    task automatic wait_valid(input bit is_if, input int limit, input string name);
        int n;
        n = 0;
        while (!(is_if ? if_valid : mem_valid)) begin
            if (n == limit) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: no valid pulse within %0d cycles", name, limit);
                return;
            end
            tick();
            n++;
        end
    endtask

    task automatic rand_drive();
        if_cancel = 1'b0;
        if (m_if_valid) begin
            if_req  = 1'($urandom_range(0, 1));
            if_addr = 32'($urandom_range(0, 255)) << 2;
        end else if (if_req) begin
            if ($urandom_range(0, 15) == 0) begin
                if_cancel = 1'b1;
                if_addr   = 32'($urandom_range(0, 255)) << 2;
            end
        end else if ($urandom_range(0, 2) == 0) begin
            if_req  = 1'b1;
            if_addr = 32'($urandom_range(0, 255)) << 2;
        end
        if (!if_req && $urandom_range(0, 40) == 0) if_cancel = 1'b1;
        if (m_mem_valid || (!mem_req && $urandom_range(0, 2) == 0)) begin
            mem_req   = m_mem_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            mem_we    = 1'($urandom_range(0, 1));
            mem_addr  = 32'($urandom_range(0, 15)) << 2;
            mem_wdata = 32'($urandom);
        end
        reset_b = ($urandom_range(0, 299) == 0);
    endtask

    initial begin
        logic [31:0] starve_exp [6];
        int n;
        reset_b = 1'b1; if_req = 1'b0; if_addr = 32'h0; if_cancel = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
        ram_rdata = 32'h0; ram_ack = 1'b0;
        ram_store[32'h0040_0000] = 32'h2408_0005;
        ram_store[32'h0040_0008] = 32'h1234_5678;

        tick(); tick();
        check("rst_ram_req", ram_req, 1'b0);
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_ram_addr", ram_addr, 32'h0);
        check("rst_ram_wdata", ram_wdata, 32'h0);
        check("rst_if_valid", if_valid, 1'b0);
        check("rst_mem_valid", mem_valid, 1'b0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        reset_b = 1'b0;
        tick();

        // Single fetch with ack in the same cycle ram_req rises.
        ack_lat = 0;
        if_req = 1'b1; if_addr = 32'h0040_0000;
        tick();
        check("fetch_ram_req", ram_req, 1'b1);
        check("fetch_ram_addr", ram_addr, 32'h0040_0000);
        tick();
        check("fetch_valid", if_valid, 1'b1);
        check("fetch_rdata", if_rdata, 32'h2408_0005);
        if_req = 1'b0;
        tick();
        check("fetch_pulse_end", if_valid, 1'b0);

        // Store with a three-cycle request, then load it back.
        ack_lat = 2;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h10; mem_wdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("store_ram_req", ram_req, 1'b1);
            check("store_ram_we", ram_we, 1'b1);
            check("store_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
        end
        tick();
        check("store_valid", mem_valid, 1'b1);
        check("store_rdata_zero", mem_rdata, 32'h0);
        mem_we = 1'b0;
        tick();
        wait_valid(1'b0, 20, "load_valid");
        check("load_rdata", mem_rdata, 32'hDEAD_BEEF);
        mem_req = 1'b0;
        tick();

        // Contention: MEM first, IF granted out of the mem_valid cycle.
        ack_lat = 0;
        mem_req = 1'b1; mem_addr = 32'h20; if_req = 1'b1; if_addr = 32'h0040_0008;
        tick();
        check("cont_mem_first", ram_addr, 32'h20);
        tick();
        check("cont_mem_valid", mem_valid, 1'b1);
        mem_req = 1'b0;
        tick();
        check("cont_if_req", ram_req, 1'b1);
        check("cont_if_addr", ram_addr, 32'h0040_0008);
        tick();
        check("cont_if_valid", if_valid, 1'b1);
        check("cont_if_rdata", if_rdata, 32'h1234_5678);
        if_req = 1'b0;
        tick();

        // Cancel while the fetch is in flight.
        ack_lat = 2;
        if_req = 1'b1; if_addr = 32'h0040_0004;
        tick();
        check("cancel_granted", ram_req, 1'b1);
        if_cancel = 1'b1; if_req = 1'b0;
        tick();
        if_cancel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("cancel_no_valid", if_valid, 1'b0);
        end
        check("cancel_req_done", ram_req, 1'b0);
        check("cancel_rdata_kept", if_rdata, 32'h1234_5678);

        // Cancel in the ack cycle itself.
        ack_lat = 1;
        if_req = 1'b1;
        n = 0;
        tick();
        while (!ram_ack && n < 10) begin tick(); n++; end
        check("cancel_ack_seen", ram_ack, 1'b1);
        if_cancel = 1'b1; if_req = 1'b0;
        tick();
        if_cancel = 1'b0;
        check("cancel_ack_no_valid", if_valid, 1'b0);
        check("cancel_ack_req_low", ram_req, 1'b0);
        check("cancel_ack_rdata_kept", if_rdata, 32'h1234_5678);
        tick();

        // Starvation limit: both held, fetch flushed in each mem_valid cycle.
        ack_lat = 0;
        grant_q.delete();
        if_req = 1'b1; if_addr = 32'h0040_000C; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h24;
        for (int i = 0; i < 60 && grant_q.size() < 6; i++) begin
            tick();
            if_cancel = mem_valid;
        end
        mem_req = 1'b0; if_req = 1'b0; if_cancel = 1'b0;
        starve_exp = '{32'h24, 32'h24, 32'h24, 32'h24, 32'h0040_000C, 32'h24};
        check("starve_grant_count", 64'(grant_q.size()), 64'd6);
        for (int k = 0; k < 6 && k < grant_q.size(); k++)
            check("starve_grant_order", grant_q[k], starve_exp[k]);
        for (int i = 0; i < 4; i++) tick();

        // Reset in the middle of a load; a late ack must not complete it.
        ack_lat = 5;
        mem_req = 1'b1; mem_addr = 32'h30;
        tick(); tick();
        check("rst_mid_busy", ram_req, 1'b1);
        reset_b = 1'b1;
        tick();
        check("rst_mid_req_low", ram_req, 1'b0);
        reset_b = 1'b0; mem_req = 1'b0; force_ack = 1;
        tick(); tick();
        check("rst_late_ack_no_valid", mem_valid, 1'b0);
        check("rst_late_ack_idle", ram_req, 1'b0);
        tick();

        // Randomized traffic.
        rand_mode = 1;
        for (int i = 0; i < 4000; i++) begin
            tick();
            rand_drive();
        end
        rand_mode = 0;
        reset_b = 1'b0; if_req = 1'b0; mem_req = 1'b0; if_cancel = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester scheduler that shares one single-ported instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the five-stage pipeline. It arbitrates requests, sequences each transaction through a req/ack handshake with the memory, and returns read data with a one-cycle valid pulse. The requesting stage stalls until that pulse arrives. Fixed MEM-over-IF priority is tempered by a starvation limit, and IF fetches can be cancelled by branch/jump flushes.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_CONSEC, 4, max consecutive MEM grants while IF waits (≥1)

- clk  in  1  clock
- reset_b  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_valid
- if_addr  in  ADDR_W  fetch address
- if_cancel  in  1  flush pulse; kills pending/in-flight fetch
- if_rdata  out  DATA_W  fetched instruction, valid with if_valid
- if_valid  out  1  one-cycle fetch completion pulse
- mem_req  in  1  load/store request; held with mem_we/addr/wdata until mem_valid
- mem_we  in  1  1 = store
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_rdata  out  DATA_W  load data, valid with mem_valid
- mem_valid  out  1  one-cycle load/store completion pulse
- ram_req  out  1  memory request, held until ram_ack
- ram_we  out  1  memory write enable
- ram_addr  out  ADDR_W  memory address
- ram_wdata  out  DATA_W  memory write data
- ram_rdata  in  DATA_W  memory read data, sampled on ram_ack
- ram_ack  in  1  memory completion, any latency ≥0 cycles after ram_req rises

## Operation
- States: IDLE, BUSY_IF, BUSY_MEM. All ram_* and *_valid/*_rdata are registered.
- IDLE eligibility: mem_req eligible if mem_valid=0 this cycle; if_req eligible if if_valid=0 and if_cancel=0 this cycle.
- IDLE grant: only MEM eligible → BUSY_MEM; only IF → BUSY_IF; both → MEM, unless starve_cnt == MAX_CONSEC, then IF. Neither → stay IDLE.
- On grant edge: ram_req←1, ram_addr/ram_we/ram_wdata←granted requester's fields (ram_we=0 and ram_wdata=0 for IF).
- starve_cnt: +1 on each MEM grant while if_req=1; cleared on IF grant or in IDLE when if_req=0; saturates at MAX_CONSEC.
- BUSY_x: hold ram_* stable until ram_ack=1. On the ack edge: ram_req←0, x_rdata←ram_rdata (stores load 0), x_valid←1 for one cycle, state←IDLE.
- Cancel: if_cancel in BUSY_IF sets drop flag; at ack the fetch completes on the memory side but if_valid stays 0 and if_rdata is unchanged. Cancel coincident with ack also suppresses. Drop flag clears on return to IDLE. if_cancel in BUSY_MEM or IDLE without a grant has no state effect.
- ram_ack while IDLE is ignored.

## Timing
- Reset (sampled at an edge): state IDLE; ram_req, ram_we, if_valid, mem_valid = 0; ram_addr, ram_wdata, if_rdata, mem_rdata = 0; starve_cnt = 0; drop = 0. Reset mid-transaction abandons it; ram_req falls at that edge.
- Latency: request eligible in IDLE at cycle N → ram_req=1 at N+1 → ack at cycle A ≥ N+1 → x_valid=1 at A+1.
- Minimum per-transaction occupancy: 2 cycles. A new grant can be made in the cycle a valid pulse is shown, since that state is IDLE.
- Requester is expected to drop or change req in the cycle after its valid pulse; req in the valid cycle itself is never re-granted.

## Test plan
- Single fetch, ack same cycle ram_req rises: if_req at cycle 1, addr 0x0040_0000, ram_rdata 0x2408_0005 → ram_req at 2, if_valid=1 with if_rdata=0x2408_0005 at 3.
- Contention: both req at cycle 1 → MEM served first; IF granted in the mem_valid cycle; ram_addr switches to if_addr.
- Starvation: mem_req held continuously (re-raised each transaction), if_req held, MAX_CONSEC=4 → exactly 4 MEM grants, then 1 IF grant, then MEM resumes.
- Store then load, ack latency 3: mem_we=1, addr 0x10, wdata 0xDEADBEEF → ram_we=1 held 3 cycles, mem_valid pulse; then load 0x10 → mem_rdata=0xDEADBEEF.
- Cancel in flight: if_cancel pulse during BUSY_IF with ack 2 cycles later → ram_req completes, no if_valid, if_rdata unchanged; cancel on the ack cycle → same.
- Reset mid-BUSY_MEM: reset_b=1 one cycle → next cycle ram_req=0, state IDLE, late ram_ack ignored, no mem_valid.
